uart_rx_framer: RTL and testbench
=================================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, the clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115_200, the baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, the data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, the parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, the stop bits per frame; legal values 1 and 2.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-010 SHALL have port rx_valid, output, 1 bit: rx_data and the error flags hold a frame.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer accepts the frame when rx_valid && rx_ready.
REQ-012 SHALL have port parity_err, output, 1 bit: the held frame failed parity; qualified by rx_valid.
REQ-013 SHALL have port frame_err, output, 1 bit: a stop bit of the held frame sampled 0; qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer division) and MID = BPS_CNT/2; the baud counter is $clog2(BPS_CNT) bits wide.
REQ-016 SHALL pass uart_rxd through a 2-flop synchroniser whose flops reset to 1.
REQ-017 SHALL compute each bit value as the majority vote of the synchronised line at counter values MID-1, MID and MID+1.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PAR, STOP; reset state is IDLE.
REQ-019 IDLE -> START SHALL occur on a 1->0 transition of the synchronised line, with the baud counter cleared.
REQ-020 In START at MID+1, a majority of 1 SHALL be treated as a false start and SHALL return to IDLE; no frame, no flags.
REQ-021 Each bit period SHALL last BPS_CNT cycles; at counter BPS_CNT-1 the counter wraps to 0 and the FSM advances.
REQ-022 DATA SHALL capture DATA_BITS bits LSB first, then go to PAR if PARITY != 0, else to STOP.
REQ-023 PAR SHALL flag an error when XOR(data, parity bit) is 0 for odd parity, or 1 for even parity.
REQ-024 STOP SHALL sample STOP_BITS bits; any stop bit sampled 0 sets the frame error.
REQ-025 After the MID+1 vote of the last stop bit, the FSM SHALL return to IDLE immediately (half-bit early resync).
REQ-026 The output register SHALL load rx_data, parity_err and frame_err, and set rx_valid, on the cycle after the last stop vote.
REQ-027 The output register SHALL have 1-cycle latency from the last stop vote to rx_valid = 1.
REQ-028 rx_valid, rx_data and the flags SHALL stay stable until the rx_valid && rx_ready cycle; rx_valid clears on the next edge.
REQ-029 If a frame completes while rx_valid = 1 and rx_ready = 0, the new frame SHALL be dropped, the old frame kept, and overrun pulsed for 1 cycle.
REQ-030 If a frame completes in the same cycle as an accept, the new frame SHALL load, rx_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-031 A break (line held 0 through the stop bits) SHALL deliver rx_data = 0 with frame_err = 1.
REQ-032 After a break, IDLE SHALL wait for the line to return to 1 before arming start detection.
REQ-033 The receiver SHALL continue receiving while rx_valid is held; the FSM never stalls on the consumer.

Reset
REQ-034 On rst_n = 0, asynchronously: FSM = IDLE; counters = 0; synchroniser = 1; rx_data = 0; rx_valid, parity_err, frame_err, overrun = 0.
REQ-035 A reset asserted mid-frame SHALL abandon the frame with no rx_valid.
REQ-036 After release, a start SHALL be detected only on a fresh 1->0 transition.

Verification (CLK_FREQ 50 MHz, UART_BPS 115200, BPS_CNT 434)
REQ-037 8N1, send 0xA5, rx_ready = 1 -> rx_valid 1 cycle, rx_data = 0xA5, both flags 0, rx_valid rises 1 cycle after the last stop vote.
REQ-038 PARITY = 2 (8E1), send 0x03 with parity bit 1 -> rx_data = 0x03, parity_err = 1; with parity bit 0 -> parity_err = 0.
REQ-039 Send 0x55 with stop bit 0 -> frame_err = 1; hold the line low 20 bit times -> one frame, 0x00, frame_err = 1, and no further frame until the line returns high.
REQ-040 Line low for 100 cycles then high -> no rx_valid, FSM back in IDLE; a single-cycle 1 glitch at MID inside a data bit is ignored by the vote.
REQ-041 With rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; then raise rx_ready -> 0x11 is accepted.
REQ-042 Assert rst_n = 0 during data bit 4, release, then send 0x3C -> only 0x3C is delivered, with no spurious frame.

Source files
------------

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: asynchronous serial receiver with majority-vote bit sampling,
// optional parity, one or two stop bits and a valid/ready output holding register.
module uart_rx_framer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int MID     = BPS_CNT / 2;
    localparam int CW      = $clog2(BPS_CNT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   sync1;
    logic                   sync2;
    logic                   line_prev;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bad;
    logic                   stop_bad;
    logic                   s_lo;
    logic                   s_mid;

    logic at_lo;
    logic at_mid;
    logic at_vote;
    logic at_end;
    logic vote;
    logic fall;
    logic last_bit;
    logic last_stop;
    logic frame_done;

    assign at_lo      = (cnt == CW'(MID - 1));
    assign at_mid     = (cnt == CW'(MID));
    assign at_vote    = (cnt == CW'(MID + 1));
    assign at_end     = (cnt == CW'(BPS_CNT - 1));
    assign vote       = (s_lo & s_mid) | (s_lo & sync2) | (s_mid & sync2);
    assign fall       = line_prev & ~sync2;
    assign last_bit   = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
    assign frame_done = (state == STOP) && at_vote && last_stop;

    // State register for the frame sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a start only arms on a falling edge, so a held break waits for idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fall) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    next_state = IDLE;
                end else if (at_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_end && last_bit) begin
                    next_state = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (at_end) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (at_vote && last_stop) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Baud counter: held at zero in IDLE, wraps every bit period, cleared on any return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE || next_state == IDLE || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Line synchroniser, vote samples and per-frame shift/parity/stop tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            s_lo      <= 1'b1;
            s_mid     <= 1'b1;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            sync1     <= uart_rxd;
            sync2     <= sync1;
            line_prev <= sync2;
            if (at_lo) begin
                s_lo <= sync2;
            end
            if (at_mid) begin
                s_mid <= sync2;
            end
            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_bad  <= 1'b0;
                    stop_bad <= 1'b0;
                end
                DATA: begin
                    if (at_vote) begin
                        shift <= {vote, shift[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                PAR: begin
                    if (at_vote) begin
                        par_bad <= (PARITY == 1) ? ~(^shift ^ vote) : (^shift ^ vote);
                    end
                end
                STOP: begin
                    if (at_vote && !vote) begin
                        stop_bad <= 1'b1;
                    end
                    if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output holding register: a completed frame loads unless the previous one is still unaccepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift;
                    parity_err <= par_bad;
                    frame_err  <= stop_bad | ~vote;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: an 8N1 and an 8E1 receiver listen to one shared serial line.
module tb_uart_rx_framer;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 115_200;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int MID      = BPS / 2;
    // Line fall to rx_valid: two sync flops plus the edge register, nine whole bit
    // periods before the stop bit, the vote at MID+1, then the output register.
    localparam int LAT_8N1  = 3 + 9 * BPS + (MID + 1) + 1;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic       ready_b  = 1'b1;

    logic [7:0] data_a;
    logic       valid_a;
    logic       perr_a;
    logic       ferr_a;
    logic       ovr_a;
    logic [7:0] data_b;
    logic       valid_b;
    logic       perr_b;
    logic       ferr_b;
    logic       ovr_b;

    int     vectors     = 0;
    int     miscompares = 0;
    int     cycle       = 0;
    int     fall_cycle  = 0;
    int     rise_cycle  = 0;
    int     high_cnt    = 0;
    int     ovr_cnt     = 0;
    int     ovr_cnt_b   = 0;
    logic   prev_valid_a = 1'b0;
    frame_t acc_a[$];
    frame_t acc_b[$];
    int     rd_a = 0;
    int     rd_b = 0;
    logic   tx_bits[$];

    uart_rx_framer #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .DATA_BITS(8),
        .PARITY   (0),
        .STOP_BITS(1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rx_data   (data_a),
        .rx_valid  (valid_a),
        .rx_ready  (rx_ready),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .overrun   (ovr_a)
    );

    uart_rx_framer #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .DATA_BITS(8),
        .PARITY   (2),
        .STOP_BITS(1)
    ) u_dut_even (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rx_data   (data_b),
        .rx_valid  (valid_b),
        .rx_ready  (ready_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .overrun   (ovr_b)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Free-running cycle count for latency measurement.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic frame_t mk_frame(input logic [8:0] d, input logic p, input logic f);
        frame_t r;
        r.data = d;
        r.perr = p;
        r.ferr = f;
        return r;
    endfunction

    // Expected parity error from the count of ones in data plus the parity bit.
    function automatic logic parity_err_model(input logic [7:0] d, input logic pbit, input int mode);
        int ones;
        ones = $countones({d, pbit});
        return (mode == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    // Monitor away from the active edge: record accepted frames, rx_valid rises and overruns.
    always @(negedge clk) begin
        if (valid_a && rx_ready) acc_a.push_back(mk_frame({1'b0, data_a}, perr_a, ferr_a));
        if (valid_b && ready_b) acc_b.push_back(mk_frame({1'b0, data_b}, perr_b, ferr_b));
        if (valid_a && !prev_valid_a) rise_cycle <= cycle;
        if (valid_a) high_cnt <= high_cnt + 1;
        if (ovr_a) ovr_cnt <= ovr_cnt + 1;
        if (ovr_b) ovr_cnt_b <= ovr_cnt_b + 1;
        prev_valid_a <= valid_a;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_frame(input string tag, input frame_t q[$], inout int rd,
                               input logic [8:0] d, input logic p, input logic f);
        frame_t got;
        vectors++;
        assert (rd < q.size())
        else begin
            miscompares++;
            $error("[TB] FAIL %s_present: observed %0d frames expected at least %0d", tag, q.size(), rd + 1);
        end
        if (rd < q.size()) begin
            got = q[rd];
            rd++;
            check_output({tag, "_data"}, 32'(got.data), 32'(d));
            check_output({tag, "_perr"}, 32'(got.perr), 32'(p));
            check_output({tag, "_ferr"}, 32'(got.ferr), 32'(f));
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 uart_rxd = v;
        end
    endtask

    task automatic build_frame(input logic [7:0] d, input int par_mode, input logic pbit, input logic stop_val);
        tx_bits.delete();
        tx_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_bits.push_back(d[i]);
        if (par_mode != 0) tx_bits.push_back(pbit);
        tx_bits.push_back(stop_val);
    endtask

    // Drive tx_bits plus one idle bit; optionally glitch one bit at mid, pulse rx_ready, or abort with reset.
    task automatic apply_stimulus(input int glitch_bit, input int ready_k, input int abort_k);
        int   k;
        logic v;
        k = 0;
        for (int b = 0; b <= tx_bits.size(); b++) begin
            v = (b < tx_bits.size()) ? tx_bits[b] : 1'b1;
            for (int c = 0; c < BPS; c++) begin
                @(posedge clk);
                #1;
                if (k == 0) fall_cycle = cycle;
                if (k == abort_k) begin
                    rst_n    = 1'b0;
                    uart_rxd = 1'b1;
                    return;
                end
                uart_rxd = (b == glitch_bit && c == MID) ? ~v : v;
                if (ready_k >= 0 && k == ready_k) rx_ready = 1'b1;
                if (ready_k >= 0 && k == ready_k + 1) rx_ready = 1'b0;
                k++;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        int         base_high;
        int         base_ovr;

        // Reset state.
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_valid", 32'(valid_a), 32'd0);
        check_output("reset_data", 32'(data_a), 32'd0);
        check_output("reset_perr", 32'(perr_a), 32'd0);
        check_output("reset_ferr", 32'(ferr_a), 32'd0);
        check_output("reset_ovr", 32'(ovr_a), 32'd0);
        check_output("reset_valid_even", 32'(valid_b), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_line(1'b1, BPS);

        // 0xA5, 8N1: latency, single-cycle valid, clean flags.
        base_high = high_cnt;
        build_frame(8'hA5, 0, 1'b0, 1'b1);
        apply_stimulus(-1, -1, -1);
        check_output("a5_latency", 32'(rise_cycle - fall_cycle), 32'(LAT_8N1));
        check_output("a5_valid_width", 32'(high_cnt - base_high), 32'd1);
        check_frame("a5", acc_a, rd_a, 9'h0A5, 1'b0, 1'b0);
        check_output("a5_count", 32'(acc_a.size()), 32'(rd_a));

        // Random bytes against the model.
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            build_frame(d, 0, 1'b0, 1'b1);
            apply_stimulus(-1, -1, -1);
            check_frame("rand", acc_a, rd_a, {1'b0, d}, 1'b0, 1'b0);
            check_output("rand_count", 32'(acc_a.size()), 32'(rd_a));
        end

        // Even parity receiver: 0x03 with parity bit 1 then 0; the 8N1 receiver sees the parity bit as stop.
        rd_b = acc_b.size();
        build_frame(8'h03, 2, 1'b1, 1'b1);
        apply_stimulus(-1, -1, -1);
        check_frame("par1_even", acc_b, rd_b, 9'h003, parity_err_model(8'h03, 1'b1, 2), 1'b0);
        check_frame("par1_8n1", acc_a, rd_a, 9'h003, 1'b0, 1'b0);
        build_frame(8'h03, 2, 1'b0, 1'b1);
        apply_stimulus(-1, -1, -1);
        check_frame("par0_even", acc_b, rd_b, 9'h003, parity_err_model(8'h03, 1'b0, 2), 1'b0);
        check_frame("par0_8n1", acc_a, rd_a, 9'h003, 1'b0, 1'b1);
        check_output("par_count_even", 32'(acc_b.size()), 32'(rd_b));

        // 0x55 with a zero stop bit.
        build_frame(8'h55, 0, 1'b0, 1'b0);
        apply_stimulus(-1, -1, -1);
        check_frame("stop0", acc_a, rd_a, 9'h055, 1'b0, 1'b1);
        check_output("stop0_count", 32'(acc_a.size()), 32'(rd_a));

        // Break: 20 bit times low gives exactly one zero frame with frame error.
        drive_line(1'b0, 20 * BPS);
        check_frame("break", acc_a, rd_a, 9'h000, 1'b0, 1'b1);
        check_output("break_count_low", 32'(acc_a.size()), 32'(rd_a));
        drive_line(1'b1, 2 * BPS);
        check_output("break_count_idle", 32'(acc_a.size()), 32'(rd_a));

        // False start: 100 cycles low, then idle.
        drive_line(1'b0, 100);
        drive_line(1'b1, 2 * BPS);
        check_output("false_start_count", 32'(acc_a.size()), 32'(rd_a));

        // Single-cycle glitch at mid of data bit 2 of 0xC3.
        build_frame(8'hC3, 0, 1'b0, 1'b1);
        apply_stimulus(3, -1, -1);
        check_frame("glitch", acc_a, rd_a, 9'h0C3, 1'b0, 1'b0);

        // Overrun: 0x11 held, 0x22 dropped.
        rx_ready = 1'b0;
        base_ovr = ovr_cnt;
        build_frame(8'h11, 0, 1'b0, 1'b1);
        apply_stimulus(-1, -1, -1);
        build_frame(8'h22, 0, 1'b0, 1'b1);
        apply_stimulus(-1, -1, -1);
        check_output("ovr_hold_valid", 32'(valid_a), 32'd1);
        check_output("ovr_hold_data", 32'(data_a), 32'h11);
        check_output("ovr_pulses", 32'(ovr_cnt - base_ovr), 32'd1);
        check_output("ovr_count", 32'(acc_a.size()), 32'(rd_a));

        // 0x33 completes in the very cycle 0x11 is accepted: load, no overrun.
        build_frame(8'h33, 0, 1'b0, 1'b1);
        apply_stimulus(-1, LAT_8N1 - 1, -1);
        check_frame("ovr_accept", acc_a, rd_a, 9'h011, 1'b0, 1'b0);
        check_output("same_cycle_valid", 32'(valid_a), 32'd1);
        check_output("same_cycle_data", 32'(data_a), 32'h33);
        check_output("same_cycle_ovr", 32'(ovr_cnt - base_ovr), 32'd1);
        rx_ready = 1'b1;
        drive_line(1'b1, 4);
        check_frame("drain", acc_a, rd_a, 9'h033, 1'b0, 1'b0);
        check_output("drain_valid", 32'(valid_a), 32'd0);

        // Reset during data bit 4, then 0x3C is the only frame delivered.
        build_frame(8'h96, 0, 1'b0, 1'b1);
        apply_stimulus(-1, -1, 5 * BPS + MID);
        repeat (3) @(negedge clk);
        check_output("midreset_valid", 32'(valid_a), 32'd0);
        check_output("midreset_data", 32'(data_a), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_line(1'b1, BPS);
        check_output("midreset_count", 32'(acc_a.size()), 32'(rd_a));
        build_frame(8'h3C, 0, 1'b0, 1'b1);
        apply_stimulus(-1, -1, -1);
        check_frame("after_reset", acc_a, rd_a, 9'h03C, 1'b0, 1'b0);
        check_output("after_reset_count", 32'(acc_a.size()), 32'(rd_a));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
